// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode encoding, instruction field positions and decode bundle
package decode_pkg;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int FD_HI   = 26;
    localparam int FD_LO   = 18;
    localparam int FS_HI   = 17;
    localparam int FS_LO   = 9;
    localparam int FT_HI   = 8;
    localparam int FT_LO   = 0;
    localparam int IMM_HI  = 17;
    localparam int IMM_LO  = 0;
    localparam int FIELD_W = 9;
    localparam int IMM_W   = 18;

    typedef enum logic [4:0] {
        OP_LV  = 5'd1,
        OP_ADD = 5'd2,
        OP_SUB = 5'd3,
        OP_AND = 5'd4,
        OP_OR  = 5'd5,
        OP_CP  = 5'd6,
        OP_B   = 5'd7,
        OP_BEQ = 5'd8,
        OP_SLR = 5'd9,
        OP_GP  = 5'd10
    } opcode_e;

    // Width-independent decode result; register fields stay 9 bits and are truncated by the user.
    typedef struct packed {
        logic [4:0]         opcode;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] src_a;
        logic [FIELD_W-1:0] src_b;
        logic               use_a;
        logic               use_b;
        logic               a_lit;
        logic [IMM_W-1:0]   imm;
        logic [IMM_W-1:0]   lit;
        logic               writes;
        logic               illegal;
    } decode_ctrl_t;

    function automatic decode_ctrl_t decode_fields(input logic [31:0] instr);
        decode_ctrl_t       c;
        logic [FIELD_W-1:0] fd;
        logic [FIELD_W-1:0] fs;
        logic [FIELD_W-1:0] ft;
        c      = '0;
        fd     = instr[FD_HI:FD_LO];
        fs     = instr[FS_HI:FS_LO];
        ft     = instr[FT_HI:FT_LO];
        c.opcode = instr[OPC_HI:OPC_LO];
        case (instr[OPC_HI:OPC_LO])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.rd     = fd;
                c.src_a  = fs;
                c.use_a  = 1'b1;
                c.src_b  = ft;
                c.use_b  = 1'b1;
                c.writes = 1'b1;
            end
            OP_LV, OP_CP: begin
                c.rd     = fd;
                c.imm    = instr[IMM_HI:IMM_LO];
                c.writes = 1'b1;
            end
            OP_B: begin
                c.rd = {2'b00, instr[6:0]};
            end
            OP_BEQ: begin
                c.src_a = fd;
                c.use_a = 1'b1;
                c.src_b = fs;
                c.use_b = 1'b1;
                c.imm   = {{(IMM_W-FIELD_W){1'b0}}, ft};
            end
            OP_SLR: begin
                c.rd     = fd;
                c.src_a  = fd;
                c.use_a  = 1'b1;
                c.src_b  = ft;
                c.use_b  = 1'b1;
                c.writes = 1'b1;
            end
            OP_GP: begin
                c.a_lit = 1'b1;
                c.lit   = instr[IMM_HI:IMM_LO];
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - instruction input and decoded output handshakes of the decode stage
interface decode_stage_if #(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 5,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;

    logic               out_valid;
    logic               out_ready;
    logic [4:0]         out_opcode;
    logic [IDX_W-1:0]   out_rd;
    logic [DATA_W-1:0]  out_a;
    logic [DATA_W-1:0]  out_b;
    logic [17:0]        out_imm;
    logic               out_writes;
    logic               out_illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_a, out_b,
               out_imm, out_writes, out_illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_a, out_b,
               out_imm, out_writes, out_illegal
    );
endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file with two combinational read ports forwarding same-cycle writeback
module regfile_bypass #(
    parameter int  DATA_W = 32,
    parameter int  NREGS  = 32,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  ra_idx,
    output logic [DATA_W-1:0] ra_data,
    input  logic [IDX_W-1:0]  rb_idx,
    output logic [DATA_W-1:0] rb_data
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        ra_data = (wr_en && (wr_idx == ra_idx)) ? wr_data : regs_q[ra_idx];
        rb_data = (wr_en && (wr_idx == rb_idx)) ? wr_data : regs_q[rb_idx];
    end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with operand fetch, scoreboard stall and one-entry output register
module decode_stage
    import decode_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  NREGS   = 32,
    parameter int  INSTR_W = 32,
    localparam int IDX_W   = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    decode_stage_if.slave     dif,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);
    localparam int EXT_W = (DATA_W < IMM_W) ? DATA_W : IMM_W;

    decode_ctrl_t      ctrl;
    logic              ctrl_unused;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  src_a_idx;
    logic [IDX_W-1:0]  src_b_idx;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] lit_ext;
    logic              hazard;
    logic              in_ready;
    logic              accept;

    logic [NREGS-1:0]  pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_opcode_q, out_opcode_d;
    logic [IDX_W-1:0]  out_rd_q, out_rd_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [IMM_W-1:0]  out_imm_q, out_imm_d;
    logic              out_writes_q, out_writes_d;
    logic              out_illegal_q, out_illegal_d;

    always_comb begin
        ctrl = decode_fields(dif.instr[31:0]);
    end

    // Upper register-field bits beyond IDX_W are intentionally ignored.
    assign ctrl_unused = ^ctrl;
    assign rd_idx      = ctrl.rd[IDX_W-1:0];
    assign src_a_idx   = ctrl.src_a[IDX_W-1:0];
    assign src_b_idx   = ctrl.src_b[IDX_W-1:0];

    always_comb begin
        lit_ext              = '0;
        lit_ext[EXT_W-1:0]   = ctrl.lit[EXT_W-1:0];
    end

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wb_en),
        .wr_idx  (wb_idx),
        .wr_data (wb_data),
        .ra_idx  (src_a_idx),
        .ra_data (rd_a),
        .rb_idx  (src_b_idx),
        .rb_data (rd_b)
    );

    // A pending source resolves in the same cycle its writeback arrives, via the bypass.
    always_comb begin
        hazard = (ctrl.use_a && pending_q[src_a_idx] && !(wb_en && (wb_idx == src_a_idx))) ||
                 (ctrl.use_b && pending_q[src_b_idx] && !(wb_en && (wb_idx == src_b_idx)));
        in_ready = !hazard && (!out_valid_q || dif.out_ready) && !flush;
        accept   = dif.in_valid && in_ready;
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_idx] = 1'b0;
        end
        if (flush && out_valid_q && out_writes_q) begin
            pending_d[out_rd_q] = 1'b0;
        end
        if (accept && ctrl.writes) begin
            pending_d[rd_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_rd_d      = out_rd_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_imm_d     = out_imm_q;
        out_writes_d  = out_writes_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_opcode_d  = ctrl.opcode;
            out_rd_d      = rd_idx;
            out_a_d       = ctrl.use_a ? rd_a : (ctrl.a_lit ? lit_ext : '0);
            out_b_d       = ctrl.use_b ? rd_b : '0;
            out_imm_d     = ctrl.imm;
            out_writes_d  = ctrl.writes;
            out_illegal_d = ctrl.illegal;
        end else if (dif.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q     <= '0;
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_imm_q     <= '0;
            out_writes_q  <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_rd_q      <= out_rd_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_imm_q     <= out_imm_d;
            out_writes_q  <= out_writes_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign dif.in_ready    = in_ready;
    assign dif.out_valid   = out_valid_q;
    assign dif.out_opcode  = out_opcode_q;
    assign dif.out_rd      = out_rd_q;
    assign dif.out_a       = out_a_q;
    assign dif.out_b       = out_b_q;
    assign dif.out_imm     = out_imm_q;
    assign dif.out_writes  = out_writes_q;
    assign dif.out_illegal = out_illegal_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32, register and operand width.
REQ-002 Parameter NREGS, default 32, register-file depth; power of two, 2..512; IDX_W = clog2(NREGS).
REQ-003 Parameter INSTR_W, default 32, instruction width; fixed fields below assume 32.
REQ-004 Port clock  in  1  sole clock, rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port in_valid  in  1; in_ready  out  1: instruction handshake.
REQ-007 Port instr  in  INSTR_W  instruction: [31:27] opcode, [26:18] fd, [17:9] fs, [8:0] ft, [17:0] imm.
REQ-008 Port wb_en  in  1; wb_idx  in  IDX_W; wb_data  in  DATA_W: writeback.
REQ-009 Port flush  in  1  discard the held decoded instruction.
REQ-010 Port out_valid  out  1; out_ready  in  1: decoded-output handshake.
REQ-011 Ports out_opcode  out  5; out_rd  out  IDX_W; out_a, out_b  out  DATA_W; out_imm  out  18; out_writes  out  1; out_illegal  out  1.

Function
REQ-012 Register index = low IDX_W bits of a 9-bit field; no hardwired zero register.
REQ-013 Decode per opcode: 2-5 ALU: rd=fd, a=R[fs], b=R[ft], writes=1.
REQ-014 1 LV and 6 CP: rd=fd, a=0, b=0, imm=instr[17:0], writes=1.
REQ-015 7 B: rd=instr[6:0] truncated to IDX_W, a=b=0, writes=0.
REQ-016 8 BEQ: a=R[fd], b=R[fs], imm=ft zero-extended, writes=0.
REQ-017 9 SLR: rd=fd, a=R[fd], b=R[ft], writes=1.
REQ-018 10 GP: rd=0, a=instr[17:0] zero-extended, writes=0.
REQ-019 Other opcodes: out_illegal=1, writes=0, a=b=imm=0; no source hazard check.
REQ-020 Fields unused by an opcode output 0; 18-bit values zero-extend or truncate to DATA_W.
REQ-021 Output register: loads on in_valid && in_ready; latency 1 cycle.
REQ-022 in_ready = !hazard && (!out_valid || out_ready) && !flush.
REQ-023 Scoreboard: NREGS pending bits; set at rd on accept with writes=1; cleared at wb_idx on wb_en.
REQ-024 Simultaneous set and clear of same index: set wins.
REQ-025 hazard = any source register read by the opcode is pending and not matched by wb_en/wb_idx this cycle.
REQ-026 Bypass: source index equal to wb_idx with wb_en high yields wb_data, not stale R[].
REQ-027 Register write R[wb_idx]<=wb_data on wb_en, regardless of pending state.
REQ-028 out_valid held with all outputs stable while out_ready low.
REQ-029 flush: next cycle out_valid=0; if held instruction had writes=1, its pending bit clears; flush beats a concurrent accept.

Reset
REQ-030 reset_n low: all R[]=0, all pending=0, out_valid=0, all out_* data=0, immediately and asynchronously.
REQ-031 Reset mid-handshake drops the held instruction; first accept allowed one cycle after reset_n rises.

Structure
REQ-032 Package decode_pkg holds opcode enum (OP_LV=1 .. OP_GP=10), field bit positions, and decoded-bundle struct.
REQ-033 One sub-module regfile_bypass (NREGS x DATA_W, two combinational read ports with writeback bypass, one write port).

Verification
REQ-034 Reset, wb R3=0x1234 and R4=0x10, ADD(2) fd=5 fs=3 ft=4 -> next cycle out_a=0x1234, out_b=0x10, out_rd=5, out_writes=1.
REQ-035 LV fd=7 imm=0x3FFFF, then SUB fs=7 -> in_ready=0 until wb_en idx 7; same-cycle wb_data=0xAA -> out_a=0xAA.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction accepted.
REQ-037 Opcode 0x1F -> out_illegal=1, out_writes=0, out_a=out_b=0; scoreboard unchanged.
REQ-038 Held LV fd=9 with flush=1 -> out_valid=0 next cycle, pending[9]=0, dependent ADD fs=9 accepted without stall.
REQ-039 reset_n pulsed low while out_valid=1 and pending[2]=1 -> out_valid=0, pending all 0, R[2] reads 0.
